// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Sequencing controller for a 3-digit multiplexed 7-segment
//            display. A binary value accepted through a load handshake is
//            converted to BCD by shift-add-3 (one bit per cycle), then the
//            three digits are time-multiplexed with a programmable on-time,
//            an optional all-off dead-time and leading-zero blanking.
// Ports    : clk          system clock
//            rst          asynchronous reset, active low
//            value_in     binary value, sampled when a load is accepted
//            load         load request, level sampled
//            lz_en        leading-zero blanking enable (live)
//            load_ack     one-cycle pulse, load accepted
//            busy         conversion in progress
//            done         one-cycle pulse, new BCD value committed
//            ovf          last accepted value exceeded 999 (saturated)
//            nibble       BCD digit for the nibble encoder
//            digit_blank  current slot is blanked or dead
//            sel_seg      anode select, active low, bit3 always 1
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
   parameter int SCAN_DIV = 12500,
   parameter int DEAD_CYC = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] value_in,
   input  logic       load,
   input  logic       lz_en,
   output logic       load_ack,
   output logic       busy,
   output logic       done,
   output logic       ovf,
   output logic [3:0] nibble,
   output logic       digit_blank,
   output logic [3:0] sel_seg
);

   // The slot counter only has to reach the larger of the two periods minus one.
   localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] C_ACTIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] C_DEAD_LAST   = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
   localparam logic [3:0]       C_ITER_LAST   = 4'd9;
   localparam logic [9:0]       C_BCD_MAX     = 10'd999;
   localparam logic [3:0]       C_ANODE_OFF   = 4'b1111;

   typedef enum logic [1:0] {
      START  = 2'd0,
      ACTIVE = 2'd1,
      DEAD   = 2'd2
   } scan_state_t;

   // ------------------------------------------------------------------------
   // Binary to BCD conversion
   // ------------------------------------------------------------------------
   logic [9:0]  r_bin;
   logic [11:0] r_work;
   logic [3:0]  r_iter;
   logic [11:0] r_disp;

   logic        w_accept;
   logic        w_commit;
   logic [9:0]  w_sat;
   logic [11:0] w_work_adj;
   logic [11:0] w_work_step;
   logic [11:0] w_disp_nxt;

   function automatic logic [3:0] dabble_adj(input logic [3:0] d);
      if (d >= 4'd5) begin
         return d + 4'd3;
      end
      return d;
   endfunction

   assign w_accept    = load && !busy;
   assign w_sat       = (value_in > C_BCD_MAX) ? C_BCD_MAX : value_in;
   assign w_work_adj  = {dabble_adj(r_work[11:8]), dabble_adj(r_work[7:4]), dabble_adj(r_work[3:0])};
   assign w_work_step = (w_work_adj << 1) | {11'd0, r_bin[9]};
   // The tenth iteration commits its own result straight into the display
   // register, so the partially shifted work value is never visible.
   assign w_commit    = busy && (r_iter == C_ITER_LAST);
   assign w_disp_nxt  = w_commit ? w_work_step : r_disp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_ack <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         r_bin    <= '0;
         r_work   <= '0;
         r_iter   <= '0;
         r_disp   <= '0;
      end else begin
         load_ack <= w_accept;
         done     <= w_commit;
         r_disp   <= w_disp_nxt;
         if (w_accept) begin
            busy   <= 1'b1;
            ovf    <= (value_in > C_BCD_MAX);
            r_bin  <= w_sat;
            r_work <= '0;
            r_iter <= '0;
         end else if (busy) begin
            r_work <= w_work_step;
            r_bin  <= r_bin << 1;
            r_iter <= r_iter + 4'd1;
            if (w_commit) begin
               busy <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scan sequencer
   // ------------------------------------------------------------------------
   scan_state_t      r_state;
   scan_state_t      w_state_nxt;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx_nxt;
   logic [1:0]       w_idx_inc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_idx_inc = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      case (r_state)
         START: begin
            w_state_nxt = ACTIVE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
         end
         ACTIVE: begin
            if (r_cnt == C_ACTIVE_LAST) begin
               w_cnt_nxt = '0;
               if (DEAD_CYC == 0) begin
                  w_idx_nxt = w_idx_inc;
               end else begin
                  w_state_nxt = DEAD;
               end
            end
         end
         DEAD: begin
            if (r_cnt == C_DEAD_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ACTIVE;
               w_idx_nxt   = w_idx_inc;
            end
         end
         default: begin
            w_state_nxt = START;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are built from the next-cycle slot and the next-cycle display
   // value, so a slot that opens on the commit edge already shows the new BCD.
   logic [3:0] w_digit;
   logic [3:0] w_anode;
   logic       w_hund_zero;
   logic       w_tens_zero;
   logic       w_blank_lz;

   always_comb begin
      w_digit = w_disp_nxt[3:0];
      w_anode = C_ANODE_OFF;
      case (w_idx_nxt)
         2'd0: begin
            w_digit = w_disp_nxt[3:0];
            w_anode = 4'b1110;
         end
         2'd1: begin
            w_digit = w_disp_nxt[7:4];
            w_anode = 4'b1101;
         end
         2'd2: begin
            w_digit = w_disp_nxt[11:8];
            w_anode = 4'b1011;
         end
         default: begin
            w_digit = w_disp_nxt[3:0];
            w_anode = C_ANODE_OFF;
         end
      endcase
   end

   assign w_hund_zero = (w_disp_nxt[11:8] == 4'd0);
   assign w_tens_zero = (w_disp_nxt[7:4] == 4'd0);
   // Units are never blanked; tens only when hundreds are blank too.
   assign w_blank_lz  = lz_en && (((w_idx_nxt == 2'd2) && w_hund_zero) ||
                                  ((w_idx_nxt == 2'd1) && w_hund_zero && w_tens_zero));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= START;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         nibble      <= 4'd0;
         digit_blank <= 1'b1;
         sel_seg     <= C_ANODE_OFF;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         nibble  <= w_digit;
         if (w_state_nxt == ACTIVE) begin
            digit_blank <= w_blank_lz;
            sel_seg     <= w_blank_lz ? C_ANODE_OFF : w_anode;
         end else begin
            digit_blank <= 1'b1;
            sel_seg     <= C_ANODE_OFF;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Self-checking bench for display_scan_ctrl. One instance runs
//            with SCAN_DIV=4/DEAD_CYC=2, a second with SCAN_DIV=4/DEAD_CYC=0;
//            both share stimulus. Conversions come from a vector table and
//            the scan pattern is predicted from the cycle count since reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

   logic       clk;
   logic       rst;
   logic [9:0] value_in;
   logic       load;
   logic       lz_en;

   logic       load_ack, busy, done, ovf, digit_blank;
   logic [3:0] nibble, sel_seg;
   logic       load_ack0, busy0, done0, ovf0, digit_blank0;
   logic [3:0] nibble0, sel_seg0;

   int n_checks = 0;
   int n_errors = 0;
   int unsigned edges;

   display_scan_ctrl #(.SCAN_DIV(4), .DEAD_CYC(2)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_en(lz_en),
      .load_ack(load_ack), .busy(busy), .done(done), .ovf(ovf),
      .nibble(nibble), .digit_blank(digit_blank), .sel_seg(sel_seg)
   );

   display_scan_ctrl #(.SCAN_DIV(4), .DEAD_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_en(lz_en),
      .load_ack(load_ack0), .busy(busy0), .done(done0), .ovf(ovf0),
      .nibble(nibble0), .digit_blank(digit_blank0), .sel_seg(sel_seg0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges seen since reset release; edge 1 leaves START.
   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   typedef struct {
      logic [9:0]  val;
      logic        lz;
      logic [11:0] bcd;
      logic        ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Predict the scan outputs n edges after reset release.
   task automatic scan_cmp(input string tag, input bit nodead, input int unsigned n,
                           input logic [11:0] bcd, input logic lz,
                           input logic [3:0] sel, input logic blank, input logic [3:0] nib);
      int          period, slot_len, p, slot;
      bit          active;
      logic        bl;
      logic [3:0]  exp_sel;
      logic [3:0]  digit;
      if (n == 0) begin
         chk({tag, "_start_sel"}, {12'd0, sel}, 16'h000F);
         chk({tag, "_start_blank"}, {15'd0, blank}, 16'h0001);
      end else begin
         period   = nodead ? 12 : 18;
         slot_len = nodead ? 4 : 6;
         p        = int'((n - 1) % period);
         slot     = p / slot_len;
         active   = (p % slot_len) < 4;
         digit    = bcd[slot*4 +: 4];
         bl       = lz && ((slot == 2 && bcd[11:8] == 4'd0) ||
                           (slot == 1 && bcd[11:4] == 8'd0));
         if (active) begin
            exp_sel = bl ? 4'b1111 : ~(4'b0001 << slot);
            chk({tag, "_sel"}, {12'd0, sel}, {12'd0, exp_sel});
            chk({tag, "_blank"}, {15'd0, blank}, {15'd0, bl});
            chk({tag, "_nibble"}, {12'd0, nib}, {12'd0, digit});
         end else begin
            chk({tag, "_dead_sel"}, {12'd0, sel}, 16'h000F);
            chk({tag, "_dead_blank"}, {15'd0, blank}, 16'h0001);
         end
      end
   endtask

   task automatic check_scan(input logic [11:0] bcd, input logic lz, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         tick();
         chk("done_idle", {15'd0, done}, 16'h0000);
         chk("busy_idle", {15'd0, busy}, 16'h0000);
         scan_cmp("scan", 1'b0, edges, bcd, lz, sel_seg, digit_blank, nibble);
         scan_cmp("scan_nodead", 1'b1, edges, bcd, lz, sel_seg0, digit_blank0, nibble0);
      end
   endtask

   // One conversion. With keep=1 the load request is already on the pins.
   // At edge reload_at (counted from the ack) a second load of v2 is raised:
   // held through done when pulse=0, a single cycle when pulse=1.
   task automatic do_conv(input logic [9:0] v, input logic [9:0] v2, input int reload_at,
                          input logic ovf_exp, input bit keep, input bit pulse);
      bit got;
      if (!keep) begin
         value_in = v;
         load     = 1'b1;
      end
      tick();
      chk("load_ack", {15'd0, load_ack}, 16'h0001);
      chk("busy_set", {15'd0, busy}, 16'h0001);
      load = 1'b0;
      got  = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         if (k == reload_at) begin
            value_in = v2;
            load     = 1'b1;
         end
         if (pulse && k == reload_at + 1) load = 1'b0;
         tick();
         if (done) begin
            chk("done_latency", 16'(k), 16'd10);
            chk("busy_clear", {15'd0, busy}, 16'h0000);
            chk("ovf", {15'd0, ovf}, {15'd0, ovf_exp});
            chk("ack_on_done", {15'd0, load_ack}, 16'h0000);
            got = 1'b1;
         end else begin
            chk("ack_while_busy", {15'd0, load_ack}, 16'h0000);
         end
      end
      if (!got) chk("done_timeout", 16'h0000, 16'h0001);
   endtask

   task automatic check_reset_vals();
      chk("rst_busy", {15'd0, busy}, 16'h0000);
      chk("rst_ack", {15'd0, load_ack}, 16'h0000);
      chk("rst_done", {15'd0, done}, 16'h0000);
      chk("rst_ovf", {15'd0, ovf}, 16'h0000);
      chk("rst_nibble", {12'd0, nibble}, 16'h0000);
      chk("rst_blank", {15'd0, digit_blank}, 16'h0001);
      chk("rst_sel", {12'd0, sel_seg}, 16'h000F);
      chk("rst_sel_nodead", {12'd0, sel_seg0}, 16'h000F);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{val: 10'd255,  lz: 1'b0, bcd: 12'h255, ovf: 1'b0};
      vecs[1] = '{val: 10'd1023, lz: 1'b0, bcd: 12'h999, ovf: 1'b1};
      vecs[2] = '{val: 10'd7,    lz: 1'b1, bcd: 12'h007, ovf: 1'b0};
      vecs[3] = '{val: 10'd42,   lz: 1'b0, bcd: 12'h042, ovf: 1'b0};
      vecs[4] = '{val: 10'd100,  lz: 1'b1, bcd: 12'h100, ovf: 1'b0};
      vecs[5] = '{val: 10'd0,    lz: 1'b1, bcd: 12'h000, ovf: 1'b0};
      vecs[6] = '{val: 10'd1000, lz: 1'b1, bcd: 12'h999, ovf: 1'b1};
      vecs[7] = '{val: 10'd999,  lz: 1'b0, bcd: 12'h999, ovf: 1'b0};

      rst      = 1'b0;
      load     = 1'b0;
      value_in = '0;
      lz_en    = 1'b0;
      repeat (3) tick();
      check_reset_vals();

      // Release between edges: START is visible for one cycle.
      rst = 1'b1;
      scan_cmp("start", 1'b0, edges, 12'h000, 1'b0, sel_seg, digit_blank, nibble);
      check_scan(12'h000, 1'b0, 36);

      for (int i = 0; i < 8; i++) begin
         lz_en = vecs[i].lz;
         do_conv(vecs[i].val, 10'd0, 0, vecs[i].ovf, 1'b0, 1'b0);
         check_scan(vecs[i].bcd, vecs[i].lz, 18);
      end

      // Single-cycle load while busy is dropped.
      lz_en = 1'b0;
      do_conv(10'd100, 10'd42, 3, 1'b0, 1'b0, 1'b1);
      check_scan(12'h100, 1'b0, 18);

      // Load held from mid-conversion through done: ignored on the done
      // edge, accepted on the following one.
      do_conv(10'd100, 10'd42, 3, 1'b0, 1'b0, 1'b0);
      do_conv(10'd0, 10'd0, 0, 1'b0, 1'b1, 1'b0);
      check_scan(12'h042, 1'b0, 18);
      lz_en = 1'b1;
      check_scan(12'h042, 1'b1, 18);

      // Saturate first so the reset has a set ovf to clear.
      lz_en = 1'b0;
      do_conv(10'd1023, 10'd0, 0, 1'b1, 1'b0, 1'b0);

      // Reset five cycles into a conversion of 500.
      value_in = 10'd500;
      load     = 1'b1;
      tick();
      chk("load_ack_500", {15'd0, load_ack}, 16'h0001);
      load = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      check_reset_vals();
      tick();
      tick();
      chk("rst_hold_done", {15'd0, done}, 16'h0000);
      rst = 1'b1;
      scan_cmp("start2", 1'b0, edges, 12'h000, 1'b0, sel_seg, digit_blank, nibble);
      check_scan(12'h000, 1'b0, 36);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencing controller for the 3-digit multiplexed 7-segment display.
- Accepts a binary value via a load handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Time-multiplexes the three digits with a programmable per-digit on-time and a dead-time between digits to prevent ghosting, and applies optional leading-zero blanking.
- Feeds one nibble plus a blank flag to the existing nibble encoder, and drives the active-low anode select.

Parameters:
- SCAN_DIV, 12500: clk cycles each digit anode is driven (250 us at 50 MHz); legal range ≥1.
- DEAD_CYC, 250: clk cycles with all anodes off between digits; 0 disables dead-time.

Ports:
- clk  in  1  system clock (50 MHz); the block's one and only clock.
- rst  in  1  asynchronous, active-low reset.
- value_in  in  10  binary value to display, sampled on accepted load.
- load  in  1  load request, level-sampled each cycle.
- lz_en  in  1  leading-zero blanking enable; sampled live by the scan logic.
- load_ack  out  1  one-cycle pulse: load accepted.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: new BCD value committed to display.
- ovf  out  1  last accepted value was greater than 999.
- nibble  out  4  BCD digit for the nibble encoder.
- digit_blank  out  1  current slot is blanked or dead.
- sel_seg  out  4  anode select, active-low; bit3 is always 1.

Behaviour:
- Reset values (asynchronous, rst=0): busy=0, load_ack=0, done=0, ovf=0, displayed BCD=000, nibble=0, digit_blank=1, sel_seg=4'b1111, scan FSM in START, digit index=0, counters=0.
- All outputs are registered.
- Conversion handshake:
  - load is accepted on a rising edge where load=1 and busy=0. On that edge: load_ack=1 for one cycle, busy=1.
  - The accepted value is saturated to 999 if value_in>999, with ovf set to 1; otherwise ovf is set to 0.
  - load while busy=1 is ignored; no ack is given and nothing is queued.
  - Each of the next 10 edges performs one double-dabble iteration: add 3 to any BCD nibble ≥5, then shift left 1.
  - On the 10th iteration edge: busy=0, done=1 for one cycle, and the displayed BCD register is updated atomically.
  - Total: done asserts 10 cycles after load_ack. A new load may be accepted on the edge after done.
  - The display shows the old value until done; no partial values are ever visible.
- Scan FSM (states START, ACTIVE, DEAD):
  - START: lasts one cycle after reset release, then goes to ACTIVE with idx=0.
  - ACTIVE: lasts exactly SCAN_DIV cycles. sel_seg has bit idx low (idx 0=units, 1=tens, 2=hundreds) unless the digit is blanked, in which case sel_seg=1111. nibble=BCD[idx]. digit_blank reflects blanking.
  - DEAD: lasts DEAD_CYC cycles with sel_seg=1111 and digit_blank=1. At the end of DEAD, idx advances 0→1→2→0 and the FSM returns to ACTIVE.
  - If DEAD_CYC=0, ACTIVE goes directly to ACTIVE with the next idx; anodes are never all-off between slots.
  - Frame period = 3*(SCAN_DIV+DEAD_CYC) cycles.
- Leading-zero blanking (lz_en=1):
  - Hundreds are blanked if the hundreds digit is 0.
  - Tens are blanked if both hundreds and tens are 0.
  - Units are never blanked.
  - A blanked slot still consumes its full time.
- Simultaneous events:
  - done and a slot boundary on the same edge: the new slot uses the new BCD value.
  - load on the done edge: ignored, since busy is still 1 on that edge.
- Reset mid-conversion aborts immediately. The display returns to 000; no done pulse is produced.

Test Plan:
- Reset release, SCAN_DIV=4, DEAD_CYC=2 -> 1 START cycle, then sel_seg repeats the sequence 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2; nibbles are 0,0,0.
- load value_in=255 -> load_ack pulse; done exactly 10 cycles later; nibbles units=5, tens=5, hundreds=2; ovf=0.
- load value_in=1023 -> display 999, ovf=1. Then load 7 with lz_en=1 -> ovf=0; hundreds and tens slots show sel_seg=1111 and digit_blank=1; units slot shows sel_seg=1110 with nibble=7.
- load 100 (busy), then load 42 three cycles later -> no second ack; display 100 after done; load 42 again after done -> display 042, or "42" with lz_en=1.
- DEAD_CYC=0 -> sel_seg never equals 1111 after START (lz_en=0), and the frame is 3*SCAN_DIV cycles.
- rst asserted 5 cycles into a conversion of 500 -> outputs return to reset values immediately; no done pulse; display 000 after release.
